// File: rtl/stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_packer_if
// Description : Bundles the narrow upstream (forward) valid/ready stream and
//               the wide, packed downstream (backward) stream of the packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_packer_if #(
    parameter int L = 8,
    parameter int N = 4
);
    // Narrow upstream side
    logic             ready_f;
    logic             valid_f;
    logic [L-1:0]     data_f;
    logic             last_f;

    // Wide downstream side
    logic             ready_b;
    logic             valid_b;
    logic [L*N-1:0]   data_b;
    logic [N-1:0]     keep_b;
    logic             last_b;

    // Packer view: consumes the narrow stream, produces packed words
    modport slave (
        output ready_f,
        input  valid_f,
        input  data_f,
        input  last_f,
        input  ready_b,
        output valid_b,
        output data_b,
        output keep_b,
        output last_b
    );

    // Environment view: drives beats and consumes packed words
    modport master (
        input  ready_f,
        output valid_f,
        output data_f,
        output last_f,
        output ready_b,
        input  valid_b,
        input  data_b,
        input  keep_b,
        input  last_b
    );
endinterface
`default_nettype wire

// File: rtl/stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : stream_packer
// Description : Packs N consecutive L-bit beats into one L*N-bit word, lane 0
//               first. An end-of-packet beat flushes a partial word early and
//               keep_b marks which lanes carry data. Output is fully registered.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_packer #(
    parameter int L = 8,
    parameter int N = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    stream_packer_if.slave   bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = (N - 1) * L;

    // Partial-word state: beats already collected for the word in progress
    logic [CW-1:0]  r_cnt;
    logic [AW-1:0]  r_acc;

    // Output register
    logic           r_valid;
    logic [L*N-1:0] r_data;
    logic [N-1:0]   r_keep;
    logic           r_last;

    logic           w_ready;
    logic           w_accept;
    logic           w_complete;
    logic [L*N-1:0] w_acc_ext;
    logic [L*N-1:0] w_word;
    logic [N-1:0]   w_keep;

    // Upstream may only push when the output slot is free or being drained this
    // cycle; a stalled slot blocks even non-completing beats so nothing is lost.
    assign w_ready    = rst & (~r_valid | bus.ready_b);
    assign w_accept   = bus.valid_f & w_ready;
    assign w_complete = w_accept & ((r_cnt == CW'(N - 1)) | bus.last_f);

    // Top lane is never stored in the accumulator; pad so every lane indexes
    // a legal slice.
    assign w_acc_ext  = {{L{1'b0}}, r_acc};

    // Assemble the outgoing word: stored lanes below cnt, the live beat at
    // lane cnt, zeros above.
    always_comb begin
        w_word = '0;
        w_keep = '0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) == r_cnt) begin
                w_word[i*L +: L] = bus.data_f;
                w_keep[i]        = 1'b1;
            end else if (CW'(i) < r_cnt) begin
                w_word[i*L +: L] = w_acc_ext[i*L +: L];
                w_keep[i]        = 1'b1;
            end
        end
    end

    // Accumulate beats of the word in progress; a completing beat restarts at lane 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_complete) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < N - 1; i++) begin
                if (r_cnt == CW'(i)) begin
                    r_acc[i*L +: L] <= bus.data_f;
                end
            end
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Output register: a new word load takes priority over the drain handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (w_complete) begin
            r_valid <= 1'b1;
            r_data  <= w_word;
            r_keep  <= w_keep;
            r_last  <= bus.last_f;
        end else if (r_valid && bus.ready_b) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.ready_f = w_ready;
    assign bus.valid_b = r_valid;
    assign bus.data_b  = r_data;
    assign bus.keep_b  = r_keep;
    assign bus.last_b  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_packer
// Description : Directed, table-driven self-checking bench for stream_packer
//               (L=8, N=4) plus a hand-written mid-word reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_packer;

    logic clk;
    logic rst;

    stream_packer_if #(.L(8), .N(4)) bus ();

    stream_packer #(.L(8), .N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vf;
        logic [7:0]  d;
        logic        lf;
        logic        rb;
        logic        e_rf;
        logic        e_vb;
        logic [31:0] e_db;
        logic [3:0]  e_kb;
        logic        e_lb;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic vf, input logic [7:0] d, input logic lf,
                       input logic rb, input logic e_rf, input logic e_vb,
                       input logic [31:0] e_db, input logic [3:0] e_kb,
                       input logic e_lb);
        vec_t v;
        v.vf = vf; v.d = d; v.lf = lf; v.rb = rb;
        v.e_rf = e_rf; v.e_vb = e_vb; v.e_db = e_db; v.e_kb = e_kb; v.e_lb = e_lb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check ready_f before the
    // rising edge, then let the edge happen and settle.
    task automatic cycle(input string tag, input logic r, input logic vf,
                         input logic [7:0] d, input logic lf, input logic rb,
                         input logic e_rf);
        @(negedge clk);
        rst         = r;
        bus.valid_f = vf;
        bus.data_f  = d;
        bus.last_f  = lf;
        bus.ready_b = rb;
        #1;
        check({tag, " ready_f"}, {31'd0, bus.ready_f}, {31'd0, e_rf});
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic e_vb, input logic [31:0] e_db,
                             input logic [3:0] e_kb, input logic e_lb);
        check({tag, " valid_b"}, {31'd0, bus.valid_b}, {31'd0, e_vb});
        check({tag, " data_b"},  bus.data_b, e_db);
        check({tag, " keep_b"},  {28'd0, bus.keep_b}, {28'd0, e_kb});
        check({tag, " last_b"},  {31'd0, bus.last_b}, {31'd0, e_lb});
    endtask

    initial begin
        rst         = 1'b0;
        bus.valid_f = 1'b0;
        bus.data_f  = '0;
        bus.last_f  = 1'b0;
        bus.ready_b = 1'b0;

        // Full words, 8 consecutive accepts
        add(1, 8'h11, 0, 1, 1, 0, 32'h0000_0000, 4'h0, 0);
        add(1, 8'h22, 0, 1, 1, 0, 32'h0000_0000, 4'h0, 0);
        add(1, 8'h33, 0, 1, 1, 0, 32'h0000_0000, 4'h0, 0);
        add(1, 8'h44, 0, 1, 1, 1, 32'h4433_2211, 4'hF, 0);
        add(1, 8'h55, 0, 1, 1, 0, 32'h4433_2211, 4'hF, 0);
        add(1, 8'h66, 0, 1, 1, 0, 32'h4433_2211, 4'hF, 0);
        add(1, 8'h77, 0, 1, 1, 0, 32'h4433_2211, 4'hF, 0);
        add(1, 8'h88, 0, 1, 1, 1, 32'h8877_6655, 4'hF, 0);
        // Partial flush, then next beat lands in lane 0
        add(1, 8'hA1, 0, 1, 1, 0, 32'h8877_6655, 4'hF, 0);
        add(1, 8'hA2, 0, 1, 1, 0, 32'h8877_6655, 4'hF, 0);
        add(1, 8'hA3, 1, 1, 1, 1, 32'h00A3_A2A1, 4'h7, 1);
        add(1, 8'hB1, 0, 1, 1, 0, 32'h00A3_A2A1, 4'h7, 1);
        add(1, 8'hB2, 1, 1, 1, 1, 32'h0000_B2B1, 4'h3, 1);
        // Idle with junk on data/last, then single-beat packet
        add(0, 8'hEE, 1, 1, 1, 0, 32'h0000_B2B1, 4'h3, 1);
        add(1, 8'h5C, 1, 1, 1, 1, 32'h0000_005C, 4'h1, 1);
        // Backpressure with 0x44332211 pending
        add(1, 8'h11, 0, 1, 1, 0, 32'h0000_005C, 4'h1, 1);
        add(1, 8'h22, 0, 1, 1, 0, 32'h0000_005C, 4'h1, 1);
        add(1, 8'h33, 0, 1, 1, 0, 32'h0000_005C, 4'h1, 1);
        add(1, 8'h44, 0, 0, 1, 1, 32'h4433_2211, 4'hF, 0);
        add(1, 8'h55, 1, 0, 0, 1, 32'h4433_2211, 4'hF, 0);
        add(1, 8'h55, 0, 0, 0, 1, 32'h4433_2211, 4'hF, 0);
        add(1, 8'h55, 0, 1, 1, 0, 32'h4433_2211, 4'hF, 0);
        add(1, 8'h66, 0, 1, 1, 0, 32'h4433_2211, 4'hF, 0);
        add(1, 8'h77, 0, 1, 1, 0, 32'h4433_2211, 4'hF, 0);
        add(1, 8'h88, 0, 1, 1, 1, 32'h8877_6655, 4'hF, 0);
        // Back-to-back: completing beat in the handshake cycle
        add(1, 8'h99, 1, 0, 0, 1, 32'h8877_6655, 4'hF, 0);
        add(1, 8'hC1, 1, 1, 1, 1, 32'h0000_00C1, 4'h1, 1);
        add(1, 8'hC2, 1, 1, 1, 1, 32'h0000_00C2, 4'h1, 1);
        add(1, 8'hD1, 0, 1, 1, 0, 32'h0000_00C2, 4'h1, 1);
        add(1, 8'hD2, 1, 1, 1, 1, 32'h0000_D2D1, 4'h3, 1);
        // Gappy input: 3 idle cycles between beats
        add(1, 8'hE1, 0, 1, 1, 0, 32'h0000_D2D1, 4'h3, 1);
        for (int g = 0; g < 3; g++) add(0, 8'hFF, 1, 1, 1, 0, 32'h0000_D2D1, 4'h3, 1);
        add(1, 8'hE2, 0, 1, 1, 0, 32'h0000_D2D1, 4'h3, 1);
        for (int g = 0; g < 3; g++) add(0, 8'hFF, 1, 1, 1, 0, 32'h0000_D2D1, 4'h3, 1);
        add(1, 8'hE3, 0, 1, 1, 0, 32'h0000_D2D1, 4'h3, 1);
        for (int g = 0; g < 3; g++) add(0, 8'hFF, 1, 1, 1, 0, 32'h0000_D2D1, 4'h3, 1);
        add(1, 8'hE4, 0, 1, 1, 1, 32'hE4E3_E2E1, 4'hF, 0);
        // Idle while stalled: ready_f must drop
        add(0, 8'h00, 0, 0, 0, 1, 32'hE4E3_E2E1, 4'hF, 0);

        // Reset state
        cycle("rst0", 0, 1, 8'h77, 1, 1, 0);
        cycle("rst1", 0, 1, 8'h77, 1, 1, 0);
        check_out("rst", 0, 32'h0, 4'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            cycle(tag, 1, vecs[i].vf, vecs[i].d, vecs[i].lf, vecs[i].rb, vecs[i].e_rf);
            check_out(tag, vecs[i].e_vb, vecs[i].e_db, vecs[i].e_kb, vecs[i].e_lb);
        end

        // Reset mid-word: 0x01/0x02 collected then discarded
        cycle("mr_a", 1, 1, 8'h01, 0, 1, 1);
        check_out("mr_a", 0, 32'hE4E3_E2E1, 4'hF, 0);
        cycle("mr_b", 1, 1, 8'h02, 0, 1, 1);
        cycle("mr_rst", 0, 1, 8'h03, 0, 1, 0);
        check_out("mr_rst", 0, 32'h0, 4'h0, 0);
        cycle("mr_10", 1, 1, 8'h10, 0, 1, 1);
        cycle("mr_11", 1, 1, 8'h11, 0, 1, 1);
        cycle("mr_12", 1, 1, 8'h12, 0, 1, 1);
        check_out("mr_12", 0, 32'h0, 4'h0, 0);
        cycle("mr_13", 1, 1, 8'h13, 0, 1, 1);
        check_out("mr_13", 1, 32'h1312_1110, 4'hF, 0);
        cycle("mr_end", 1, 0, 8'h00, 0, 1, 1);
        check_out("mr_end", 0, 32'h1312_1110, 4'hF, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
